// File: rtl/serial_sub.sv
// Bit-serial two's-complement subtractor: z = x - y, one bit per clock, LSB first.
// A start/busy/done handshake brackets each operation; results hold until the next completion.
module serial_sub #(
  parameter int w = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [w-1:0] x,
  input  logic [w-1:0] y,
  output logic         busy,
  output logic         done,
  output logic [w-1:0] z,
  output logic         borrow,
  output logic         overflow
);

  localparam int CNT_W = (w > 2) ? $clog2(w) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(w - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [w-1:0]     x_sh, y_sh, res_sh;
  logic [CNT_W-1:0] cnt;
  logic             b;
  logic             accept, last;
  logic             xi, yi, d_bit, b_nxt;

  // Full-subtractor cell: returns {borrow_out, difference}.
  function automatic logic [1:0] sub_cell(input logic xb, input logic yb, input logic bi);
    logic dd, bo;
    dd = xb ^ yb ^ bi;
    bo = (~xb & yb) | (~(xb ^ yb) & bi);
    return {bo, dd};
  endfunction

  assign xi             = x_sh[0];
  assign yi             = y_sh[0];
  assign {b_nxt, d_bit} = sub_cell(xi, yi, b);
  assign last           = (cnt == LAST_BIT);

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      x_sh     <= '0;
      y_sh     <= '0;
      res_sh   <= '0;
      cnt      <= '0;
      b        <= 1'b0;
      z        <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        x_sh <= x;
        y_sh <= y;
        b    <= 1'b0;
        cnt  <= '0;
      end else if (state == RUN) begin
        x_sh   <= x_sh >> 1;
        y_sh   <= y_sh >> 1;
        b      <= b_nxt;
        cnt    <= cnt + CNT_W'(1);
        res_sh <= {d_bit, res_sh[w-1:1]};
        // On the last bit the shift-register LSBs are the original operand sign bits.
        if (last) begin
          z        <= {d_bit, res_sh[w-1:1]};
          borrow   <= b_nxt;
          overflow <= (xi != yi) & (d_bit != xi);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: directed corner cases plus random operations
// compared against an arithmetic reference model.
module tb_serial_sub;

  logic        clk, rst, start;
  logic [15:0] x, y, z;
  logic        busy, done, borrow, overflow;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] hz;
  logic        hb, ho;

  serial_sub #(.w(16)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
    .busy(busy), .done(done), .z(z), .borrow(borrow), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer subtraction, unsigned compare, signed range test.
  task automatic model(input logic [15:0] a, input logic [15:0] bb,
                       output logic [15:0] ez, output logic eb, output logic eo);
    int sd;
    ez = 16'(int'(a) - int'(bb));
    eb = (int'(a) < int'(bb));
    sd = int'($signed(a)) - int'($signed(bb));
    eo = (sd > 32767) || (sd < -32768);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation (start driven in the current cycle); inj > 0 asserts a
  // spurious start after that many RUN edges. Returns in the done cycle.
  task automatic do_op(input logic [15:0] a, input logic [15:0] bb, input int inj);
    logic [15:0] ez;
    logic        eb, eo;
    int          lat;
    model(a, bb, ez, eb, eo);
    chk("ready_before_start", 32'(busy), 32'd0);
    start = 1'b1; x = a; y = bb;
    tick();
    start = 1'b0; x = 16'($urandom); y = 16'($urandom);
    chk("busy_after_accept", 32'(busy), 32'd1);
    lat = 0;
    forever begin
      tick();
      lat++;
      start = 1'b0;
      if (done === 1'b1 || lat >= 40) break;
      chk("busy_in_run", 32'(busy), 32'd1);
      chk("z_held_in_run", 32'(z), 32'(hz));
      if (lat == inj) begin
        start = 1'b1; x = 16'($urandom); y = 16'($urandom);
      end
    end
    chk("latency", 32'(lat), 32'd16);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("z", 32'(z), 32'(ez));
    chk("borrow", 32'(borrow), 32'(eb));
    chk("overflow", 32'(overflow), 32'(eo));
    hz = ez; hb = eb; ho = eo;
  endtask

  task automatic idle_after_done();
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("z_held_idle", 32'(z), 32'(hz));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; x = '0; y = '0;
    hz = '0; hb = 1'b0; ho = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_z", 32'(z), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    tick();

    do_op(16'd50, 16'd32, 0);
    chk("basic_z", 32'(z), 32'd18);
    idle_after_done();
    do_op(16'd14, 16'd23, 0);
    chk("borrow_z", 32'(z), 32'hFFF7);
    idle_after_done();
    do_op(16'h8000, 16'h0001, 0);
    chk("ovf_neg_pos", 32'(overflow), 32'd1);
    idle_after_done();
    do_op(16'h7FFF, 16'hFFFF, 0);
    chk("ovf_pos_neg_z", 32'(z), 32'h8000);
    idle_after_done();

    // Spurious start mid-run, then back-to-back accept in the done cycle.
    do_op(16'd50, 16'd32, 5);
    chk("ignored_start_z", 32'(z), 32'd18);
    do_op(16'd1, 16'd1, 0);
    chk("b2b_z", 32'(z), 32'd0);
    idle_after_done();

    // Reset in the middle of a run after a z = 18 result.
    do_op(16'd50, 16'd32, 0);
    idle_after_done();
    start = 1'b1; x = 16'd1000; y = 16'd3;
    tick();
    start = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hz = '0; hb = 1'b0; ho = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_z", 32'(z), 32'd0);
    chk("abort_borrow", 32'(borrow), 32'd0);
    chk("abort_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 20; i++) begin
      chk("abort_no_done", 32'(done), 32'd0);
      tick();
    end
    do_op(16'd1000, 16'd3, 0);
    idle_after_done();

    // Random operations, some back-to-back, some with spurious starts.
    for (int i = 0; i < 12; i++) begin
      do_op(16'($urandom), 16'($urandom), int'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) == 0) idle_after_done();
    end
    do_op(16'hFFFF, 16'h0000, 0);
    do_op(16'h0000, 16'h8000, 0);
    idle_after_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
